// File: rtl/muldiv_sched_pkg.sv
// rtl/muldiv_sched_pkg.sv - shared op codes, state encoding and default latencies for the HI/LO scheduler
package hilo_pkg;

  localparam logic [2:0] MULTU = 3'b000;
  localparam logic [2:0] MULT  = 3'b001;
  localparam logic [2:0] DIVU  = 3'b010;
  localparam logic [2:0] DIV   = 3'b011;
  localparam logic [2:0] MTHI  = 3'b100;
  localparam logic [2:0] MTLO  = 3'b101;
  localparam logic [2:0] MFHI  = 3'b110;
  localparam logic [2:0] MFLO  = 3'b111;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W_DEF       = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Bit 2 clear marks the mult/div group; bits [2:1]==10 mark mthi/mtlo.
  function automatic logic is_muldiv(input logic [2:0] op);
    return ~op[2];
  endfunction

  function automatic logic is_move_to(input logic [2:0] op);
    return (op[2:1] == 2'b10);
  endfunction

endpackage

// File: rtl/muldiv_sched_if.sv
// rtl/muldiv_sched_if.sv - EX-side request and multiply/divide control bundle for muldiv_sched
interface muldiv_sched_if;

  logic        op_valid_E;
  logic [2:0]  op_code_E;
  logic        flush_E;
  logic        id_needs_hilo;
  logic        start;
  logic [2:0]  mul_divop;
  logic        hilo_we;
  logic        hilo_sel;
  logic        busy;
  logic        done;
  logic        stall_D;
  logic        err;
  logic [15:0] done_count;

  modport master (
    output op_valid_E, op_code_E, flush_E, id_needs_hilo,
    input  start, mul_divop, hilo_we, hilo_sel, busy, done, stall_D, err, done_count
  );

  modport slave (
    input  op_valid_E, op_code_E, flush_E, id_needs_hilo,
    output start, mul_divop, hilo_we, hilo_sel, busy, done, stall_D, err, done_count
  );

endinterface

// File: rtl/muldiv_sched_lat_cnt.sv
// rtl/muldiv_sched_lat_cnt.sv - loadable latency down-counter with a last-cycle flag
module muldiv_lat_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] value_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             is_one_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturate at zero so a stray dec after completion cannot wrap the count.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = value_i;
    else if (dec_i && (cnt_q != '0))
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt_o    = cnt_q;
  assign is_one_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/muldiv_sched.sv
// rtl/muldiv_sched.sv - issue/busy sequencing, HI/LO move strobes and ID stall for the multiply/divide unit
module muldiv_sched
  import hilo_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic           clk,
  input  logic           reset,
  muldiv_sched_if.slave  bus
);

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic        err_q, err_d;
  logic [15:0] done_count_q, done_count_d;

  logic             idle;
  logic             busy;
  logic             live;
  logic             issue;
  logic             move_to;
  logic             done;
  logic             is_one;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] load_value;

  assign idle    = (state_q == IDLE);
  assign busy    = (state_q == BUSY);
  assign live    = bus.op_valid_E & ~bus.flush_E;
  assign issue   = live & is_muldiv(bus.op_code_E) & idle;
  assign move_to = live & is_move_to(bus.op_code_E) & idle;
  assign done    = busy & is_one;

  assign load_value = bus.op_code_E[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  muldiv_lat_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load_i   (issue),
    .value_i  (load_value),
    .dec_i    (busy),
    .cnt_o    (cnt),
    .is_one_o (is_one)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    err_d        = err_q | (live & busy);
    done_count_d = done_count_q + 16'(done);
    if (issue) begin
      state_d = BUSY;
      op_d    = bus.op_code_E;
    end else if (done) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      op_q         <= MULTU;
      err_q        <= 1'b0;
      done_count_q <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      err_q        <= err_d;
      done_count_q <= done_count_d;
    end
  end

  // The dependent ID op is released in the done cycle so it reaches EX after HI/LO update.
  assign bus.stall_D    = bus.id_needs_hilo & (issue | (busy & ~is_one));
  assign bus.start      = issue;
  assign bus.mul_divop  = busy ? op_q : bus.op_code_E;
  assign bus.hilo_we    = move_to;
  assign bus.hilo_sel   = ~bus.op_code_E[0];
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.err        = err_q;
  assign bus.done_count = done_count_q;

endmodule

// File: tb/tb_muldiv_sched.sv
// tb/tb_muldiv_sched.sv - directed scoreboard bench for muldiv_sched
module tb_muldiv_sched;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    logic [2:0]  op;
    int          n;
    logic [15:0] cnt;
  } sb_t;

  sb_t         sb[$];
  logic [15:0] model_count = 16'h0000;

  muldiv_sched_if bus ();

  muldiv_sched dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic fl);
    bus.op_valid_E = v;
    bus.op_code_E  = op;
    bus.flush_E    = fl;
  endtask

  task automatic issue(input logic [2:0] op, input int n);
    drive(1'b1, op, 1'b0);
    #1;
    chk("issue_start", 32'(bus.start), 32'd1);
    chk("issue_op", 32'(bus.mul_divop), 32'(op));
    chk("issue_stall", 32'(bus.stall_D), 32'(bus.id_needs_hilo));
    model_count = model_count + 16'd1;
    sb.push_back('{op: op, n: n, cnt: model_count});
  endtask

  task automatic pop_check(input int elapsed);
    sb_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk("done_op", 32'(bus.mul_divop), 32'(e.op));
    chk("done_latency", 32'(elapsed), 32'(e.n));
    tick();
    #1;
    chk("post_busy", 32'(bus.busy), 32'd0);
    chk("post_count", 32'(bus.done_count), 32'(e.cnt));
  endtask

  task automatic run_op(input logic [2:0] op, input int n);
    issue(op, n);
    for (int k = 1; k <= n; k++) begin
      tick();
      if (k == 1) drive(1'b0, 3'b000, 1'b0);
      #1;
      chk("run_busy", 32'(bus.busy), 32'd1);
      chk("run_start", 32'(bus.start), 32'd0);
      chk("run_done", 32'(bus.done), 32'(k == n));
      chk("run_stall", 32'(bus.stall_D), 32'(bus.id_needs_hilo & (k != n)));
    end
    pop_check(n);
  endtask

  task automatic wait_done(input int limit);
    int k;
    k = 0;
    while (bus.done !== 1'b1 && k < limit) begin
      tick();
      #1;
      k++;
    end
    if (bus.done !== 1'b1) chk("wait_done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    reset = 1'b0;
    bus.id_needs_hilo = 1'b0;
    drive(1'b0, 3'b000, 1'b0);
    #3;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_start", 32'(bus.start), 32'd0);
    chk("rst_we", 32'(bus.hilo_we), 32'd0);
    chk("rst_stall", 32'(bus.stall_D), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_count", 32'(bus.done_count), 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // mult with a dependent ID op
    bus.id_needs_hilo = 1'b1;
    run_op(3'b001, 5);

    // div then back-to-back div on the release cycle
    run_op(3'b011, 10);
    chk("b2b_stall_idle", 32'(bus.stall_D), 32'd0);
    run_op(3'b011, 10);
    bus.id_needs_hilo = 1'b0;

    // mthi then mtlo
    drive(1'b1, 3'b100, 1'b0);
    #1;
    chk("mthi_we", 32'(bus.hilo_we), 32'd1);
    chk("mthi_sel", 32'(bus.hilo_sel), 32'd1);
    chk("mthi_start", 32'(bus.start), 32'd0);
    tick();
    drive(1'b1, 3'b101, 1'b0);
    #1;
    chk("mtlo_we", 32'(bus.hilo_we), 32'd1);
    chk("mtlo_sel", 32'(bus.hilo_sel), 32'd0);
    chk("mtlo_busy", 32'(bus.busy), 32'd0);
    chk("mtlo_start", 32'(bus.start), 32'd0);
    tick();
    drive(1'b0, 3'b000, 1'b0);
    #1;
    chk("mt_after_busy", 32'(bus.busy), 32'd0);

    // flushed multu, then divu
    drive(1'b1, 3'b000, 1'b1);
    #1;
    chk("flush_start", 32'(bus.start), 32'd0);
    tick();
    drive(1'b0, 3'b000, 1'b0);
    #1;
    chk("flush_busy", 32'(bus.busy), 32'd0);
    chk("flush_count", 32'(bus.done_count), 32'(model_count));
    run_op(3'b010, 10);

    // reset in the middle of a div
    issue(3'b011, 10);
    tick();
    drive(1'b0, 3'b000, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_cnt", 32'(dut.cnt), 32'd0);
    chk("midrst_count", 32'(bus.done_count), 32'd0);
    sb.delete();
    model_count = 16'h0000;
    tick();
    reset = 1'b1;
    tick();
    run_op(3'b000, 5);

    // op while busy sets sticky err
    issue(3'b001, 5);
    tick();
    drive(1'b1, 3'b100, 1'b0);
    #1;
    chk("misuse_we", 32'(bus.hilo_we), 32'd0);
    chk("misuse_start", 32'(bus.start), 32'd0);
    tick();
    drive(1'b0, 3'b000, 1'b0);
    #1;
    chk("misuse_err", 32'(bus.err), 32'd1);
    chk("misuse_busy", 32'(bus.busy), 32'd1);
    wait_done(20);
    pop_check(5);
    chk("err_sticky", 32'(bus.err), 32'd1);

    // done_count wrap
    force dut.done_count_q = 16'hFFFF;
    #1;
    release dut.done_count_q;
    model_count = 16'hFFFF;
    tick();
    #1;
    chk("wrap_pre", 32'(bus.done_count), 32'h0000FFFF);
    run_op(3'b001, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_sched.md
Name: muldiv_sched

Overview:
- Sequencing controller for the HI/LO multiply/divide unit in the EX stage.
- Accepts mult/div/mthi/mtlo/mfhi/mflo ops from EX and generates the unit's start pulse, operation code and HI/LO write strobes.
- Tracks operation latency, drives busy, and produces the ID-stage stall for HI/LO-class instructions.
- Sits beside the EX pipeline register; its outputs feed the multiply/divide unit and the hazard logic.

Parameters:
- MULT_CYCLES, 5, busy cycles for multu/mult (must be ≥2).
- DIV_CYCLES, 10, busy cycles for divu/div (must be ≥2).
- CNT_W, 4, latency counter width (must hold max(MULT_CYCLES, DIV_CYCLES)).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op_valid_E  in  1  EX holds a real HI/LO-class instruction (not a bubble).
- op_code_E  in  3  000 multu, 001 mult, 010 divu, 011 div, 100 mthi, 101 mtlo, 110 mfhi, 111 mflo.
- flush_E  in  1  EX instruction cancelled this cycle.
- id_needs_hilo  in  1  ID instruction is any of the eight HI/LO-class ops.
- start  out  1  one-cycle issue pulse to the multiply/divide unit.
- mul_divop  out  3  op code to the unit; valid while start or busy.
- hilo_we  out  1  mthi/mtlo write strobe.
- hilo_sel  out  1  write target: 1 = HI, 0 = LO.
- busy  out  1  unit computing.
- done  out  1  last busy cycle; HI/LO written at the end of this cycle.
- stall_D  out  1  freeze IF/ID and bubble EX.
- err  out  1  sticky: an op arrived while busy.
- done_count  out  16  number of completed mult/div ops.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, cnt=0, op register=000, err=0, done_count=0.
  - busy=0, done=0, start=0, hilo_we=0, stall_D=0.
- Definition: issue = op_valid_E & ~flush_E & op_code_E[2]==0 & state==IDLE.
- States IDLE, BUSY.
- IDLE:
  - On issue: start=1 combinationally in the same cycle, mul_divop=op_code_E.
  - At the clock edge: op register ← op_code_E, cnt ← MULT_CYCLES if op_code_E[1]==0 else DIV_CYCLES, state ← BUSY.
- BUSY:
  - busy=1, mul_divop=op register, and cnt decrements every cycle.
  - done=1 when cnt==1; at that edge state ← IDLE and done_count increments, wrapping 0xFFFF→0x0000.
  - Timing: issue in cycle T gives busy for T+1..T+N, done in T+N, busy=0 in T+N+1.
- mthi/mtlo:
  - When op_valid_E & ~flush_E & state==IDLE: hilo_we=1 combinationally, hilo_sel = ~op_code_E[0].
  - No state change.
- mfhi/mflo: no action from this block; the read path is external.
- stall_D = id_needs_hilo & (start | (busy & cnt!=1)).
  - The dependent op is released during the done cycle, so it reaches EX at T+N+1 and sees the updated HI/LO.
- Op arriving while BUSY (op_valid_E & ~flush_E):
  - This cannot happen with correct stalling.
  - The op is ignored: no start, no hilo_we, no restart. err is set and stays set until reset.
- flush_E=1 suppresses issue, hilo_we and err in that cycle.
  - flush_E does not abort an operation already in BUSY.
- Divide by zero takes no special path: full DIV_CYCLES, done pulse as normal.
- Reset asserted mid-operation: immediate IDLE and all outputs 0.
  - The next issue after reset is accepted normally.
- Back-to-back issue: a mult/div may issue in T+N+1, giving busy again from T+N+2. There is no dead cycle beyond this.

Decomposition:
- Shared package (hilo_pkg):
  - op code constants MULTU/MULT/DIVU/DIV/MTHI/MTLO/MFHI/MFLO;
  - state encodings IDLE=1'b0, BUSY=1'b1;
  - default latency constants.
- One sub-module, muldiv_lat_cnt: loadable down-counter (load, value, dec) with cnt and is_one outputs.
- FSM, stall logic and done_count remain in muldiv_sched.

Test Plan:
- mult at T (op 001): start=1 at T only; busy T+1..T+5; done at T+5; done_count 0→1; stall_D with id_needs_hilo=1 is high T..T+4 and low at T+5.
- div at T (op 011) with id_needs_hilo held: busy T+1..T+10; done at T+10; stall_D high T..T+9; a second div issued at T+11 gives busy from T+12.
- mthi then mtlo in consecutive IDLE cycles: hilo_we=1 both cycles; hilo_sel=1 then 0; busy stays 0; start never asserted.
- flush_E=1 with op 000 valid: no start, busy stays 0, done_count unchanged. Then with op 010 valid and no flush: start=1 and busy from the next cycle.
- Reset: reset=0 at T+3 of a div → busy and done drop immediately, cnt=0; after release, a mult issues and completes in 5 cycles.
- Misuse and wrap: op 100 valid while busy → hilo_we=0 and err=1 (sticky). Force done_count=0xFFFF, complete one mult → done_count=0x0000.
